// File: rtl/decode_pkg.sv
// decode_pkg: shared constants and types for the ID/EX stage.
//   NOP_INST  - canonical RV32I nop (addi x0, x0, 0) loaded into EX on a bubble
//   CTRL_NOP  - all-zero control bundle; consumers slice it to their CTRL_W
//   lu_state_e - load-use sequencer states
package decode_pkg;

  localparam logic [31:0] NOP_INST   = 32'h0000_0013;
  localparam int          CTRL_W_MAX = 64;
  localparam logic [CTRL_W_MAX-1:0] CTRL_NOP = '0;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } lu_state_e;

endpackage

// File: rtl/load_use_detector.sv
// load_use_detector: compares the Decode source registers against a load
// sitting in EX and sequences LOAD_LAT bubbles per hazard.
// Ports:
//   i_clk, i_rst_n           clock, async active-low reset
//   i_id_vld                 Decode holds a valid instruction
//   i_rs1_addr, i_rs2_addr   Decode source register addresses
//   i_use_rs1, i_use_rs2     Decode instruction reads rs1 / rs2
//   i_ex_vld, i_ex_is_load   current EX register contents
//   i_ex_rd_addr             destination of the instruction in EX
//   i_ex_flush, i_ex_stall   redirect / backend hold from Execute
//   o_id_stall               hold PC and IF/ID (combinational)
//   o_load_bubble            this edge inserts a counted load-use bubble
//
// state | meaning
// IDLE  | no load-use sequence in progress; hazard compare active
// STALL | extra bubbles for a multi-cycle load; rem bubbles still owed
module load_use_detector
  import decode_pkg::*;
#(
  parameter int LOAD_LAT = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_id_vld,
  input  logic [4:0] i_rs1_addr,
  input  logic [4:0] i_rs2_addr,
  input  logic       i_use_rs1,
  input  logic       i_use_rs2,
  input  logic       i_ex_vld,
  input  logic       i_ex_is_load,
  input  logic [4:0] i_ex_rd_addr,
  input  logic       i_ex_flush,
  input  logic       i_ex_stall,
  output logic       o_id_stall,
  output logic       o_load_bubble
);

  localparam int REM_W = $clog2(LOAD_LAT + 1);

  lu_state_e        state_q, state_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic             hazard;

  assign hazard = i_id_vld & i_ex_vld & i_ex_is_load & (i_ex_rd_addr != 5'd0) &
                  ((i_use_rs1 & (i_rs1_addr == i_ex_rd_addr)) |
                   (i_use_rs2 & (i_rs2_addr == i_ex_rd_addr)));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    rem_d         = rem_q;
    o_id_stall    = 1'b0;
    o_load_bubble = 1'b0;
    if (i_ex_flush) begin
      state_d = IDLE;
      rem_d   = '0;
    end else if (i_ex_stall) begin
      o_id_stall = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (hazard) begin
            o_id_stall    = 1'b1;
            o_load_bubble = 1'b1;
            // The first bubble is inserted here; STALL covers the rest.
            if (LOAD_LAT > 1) begin
              state_d = STALL;
              rem_d   = REM_W'(LOAD_LAT - 1);
            end
          end
        end
        STALL: begin
          // The load has already left EX, so no hazard re-check here.
          o_id_stall    = 1'b1;
          o_load_bubble = 1'b1;
          rem_d         = rem_q - REM_W'(1);
          if (rem_q == REM_W'(1)) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: rtl/decode_hazard_pipe.sv
// decode_hazard_pipe: ID/EX pipeline register with WB->ID bypass and
// load-use bubble insertion.
// Ports:
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_id_*                         Decode bundle (pc, inst, ctrl, imm, rs data,
//                                  rs use flags, is_load, valid)
//   i_wb_rd_addr/_data/_wren       Writeback register-file write port
//   i_ex_flush                     redirect from Execute (bubble, cancel stall)
//   i_ex_stall                     backend hold (freeze everything)
//   o_ex_*                         registered Execute bundle
//   o_id_stall                     hold PC and IF/ID (combinational)
//   o_bubble_cnt                   saturating count of load-use bubbles
module decode_hazard_pipe
  import decode_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int CTRL_W   = 16,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_id_vld,
  input  logic [XLEN-1:0]   i_id_pc,
  input  logic [31:0]       i_id_inst,
  input  logic [CTRL_W-1:0] i_id_ctrl,
  input  logic [XLEN-1:0]   i_id_imm,
  input  logic [XLEN-1:0]   i_id_rs1_data,
  input  logic [XLEN-1:0]   i_id_rs2_data,
  input  logic              i_id_use_rs1,
  input  logic              i_id_use_rs2,
  input  logic              i_id_is_load,
  input  logic [4:0]        i_wb_rd_addr,
  input  logic [XLEN-1:0]   i_wb_rd_data,
  input  logic              i_wb_rd_wren,
  input  logic              i_ex_flush,
  input  logic              i_ex_stall,
  output logic              o_ex_vld,
  output logic [XLEN-1:0]   o_ex_pc,
  output logic [31:0]       o_ex_inst,
  output logic [CTRL_W-1:0] o_ex_ctrl,
  output logic [XLEN-1:0]   o_ex_imm,
  output logic [XLEN-1:0]   o_ex_rs1_data,
  output logic [XLEN-1:0]   o_ex_rs2_data,
  output logic              o_ex_is_load,
  output logic              o_id_stall,
  output logic [CNT_W-1:0]  o_bubble_cnt
);

  logic [4:0]      rs1_addr, rs2_addr;
  logic [XLEN-1:0] rs1_byp, rs2_byp;
  logic            load_bubble;

  assign rs1_addr = i_id_inst[19:15];
  assign rs2_addr = i_id_inst[24:20];

  // The regfile write lands on the same edge we register, so forward it here.
  assign rs1_byp = (i_wb_rd_wren && (i_wb_rd_addr != 5'd0) && (i_wb_rd_addr == rs1_addr))
                   ? i_wb_rd_data : i_id_rs1_data;
  assign rs2_byp = (i_wb_rd_wren && (i_wb_rd_addr != 5'd0) && (i_wb_rd_addr == rs2_addr))
                   ? i_wb_rd_data : i_id_rs2_data;

  load_use_detector #(.LOAD_LAT(LOAD_LAT)) u_lud (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_id_vld      (i_id_vld),
    .i_rs1_addr    (rs1_addr),
    .i_rs2_addr    (rs2_addr),
    .i_use_rs1     (i_id_use_rs1),
    .i_use_rs2     (i_id_use_rs2),
    .i_ex_vld      (o_ex_vld),
    .i_ex_is_load  (o_ex_is_load),
    .i_ex_rd_addr  (o_ex_inst[11:7]),
    .i_ex_flush    (i_ex_flush),
    .i_ex_stall    (i_ex_stall),
    .o_id_stall    (o_id_stall),
    .o_load_bubble (load_bubble)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ex_vld      <= 1'b0;
      o_ex_pc       <= '0;
      o_ex_inst     <= NOP_INST;
      o_ex_ctrl     <= CTRL_NOP[CTRL_W-1:0];
      o_ex_imm      <= '0;
      o_ex_rs1_data <= '0;
      o_ex_rs2_data <= '0;
      o_ex_is_load  <= 1'b0;
      o_bubble_cnt  <= '0;
    end else if (i_ex_flush || (!i_ex_stall && load_bubble)) begin
      o_ex_vld      <= 1'b0;
      o_ex_pc       <= '0;
      o_ex_inst     <= NOP_INST;
      o_ex_ctrl     <= CTRL_NOP[CTRL_W-1:0];
      o_ex_imm      <= '0;
      o_ex_rs1_data <= '0;
      o_ex_rs2_data <= '0;
      o_ex_is_load  <= 1'b0;
      // Flush bubbles are not load-use bubbles and are not counted.
      if (!i_ex_flush && (o_bubble_cnt != '1))
        o_bubble_cnt <= o_bubble_cnt + CNT_W'(1);
    end else if (!i_ex_stall) begin
      o_ex_vld      <= i_id_vld;
      o_ex_pc       <= i_id_pc;
      o_ex_inst     <= i_id_inst;
      o_ex_ctrl     <= i_id_ctrl;
      o_ex_imm      <= i_id_imm;
      o_ex_rs1_data <= rs1_byp;
      o_ex_rs2_data <= rs2_byp;
      o_ex_is_load  <= i_id_is_load;
    end
  end

endmodule

// File: doc/decode_hazard_pipe.md
# decode_hazard_pipe

Parametrised ID/EX pipeline stage for the RV32I pipeline: registers the decoded instruction bundle into Execute, applies Writeback-to-Decode bypass on register-file read data, and owns load-use hazard handling with a configurable number of bubbles for multi-cycle loads. It sits between the decoder/regfile/imm_gen in Decode and the Execute stage, replacing the fixed-width decode register stage, and drives the Fetch-side stall.

## Interface
- XLEN, 32, data/PC width
- CTRL_W, 16, width of packed control bundle (alu_op, br_un, asel, bsel, lsu_wren, slt_sl, wb_sel, rd_wren, ctrl)
- LOAD_LAT, 1, load-use bubbles per hazard (≥1)
- CNT_W, 16, bubble counter width
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_id_vld  in  1  Decode holds a valid instruction
- i_id_pc  in  XLEN  Decode PC
- i_id_inst  in  32  Decode instruction
- i_id_ctrl  in  CTRL_W  decoded control bundle
- i_id_imm  in  XLEN  immediate
- i_id_rs1_data / i_id_rs2_data  in  XLEN  regfile read data
- i_id_use_rs1 / i_id_use_rs2  in  1  instruction reads rs1 / rs2
- i_id_is_load  in  1  instruction is a load
- i_wb_rd_addr  in  5, i_wb_rd_data  in  XLEN, i_wb_rd_wren  in  1  Writeback port
- i_ex_flush  in  1  branch/jump redirect from Execute
- i_ex_stall  in  1  backend stall (hold everything)
- o_ex_vld, o_ex_pc, o_ex_inst, o_ex_ctrl, o_ex_imm, o_ex_rs1_data, o_ex_rs2_data, o_ex_is_load  out  registered Execute bundle
- o_id_stall  out  1  hold PC and IF/ID register (combinational)
- o_bubble_cnt  out  CNT_W  saturating count of load-use bubbles

## Operation
- Rs1/rs2 addresses taken from i_id_inst[19:15]/[24:20]; rd from o_ex_inst[11:7].
- Bypass: if i_wb_rd_wren, i_wb_rd_addr≠0 and equals rs1 (rs2), registered rs1 (rs2) data = i_wb_rd_data, else regfile data.
- Hazard: o_ex_vld & o_ex_is_load & rd≠0 & ((i_id_use_rs1 & rs1==rd) | (i_id_use_rs2 & rs2==rd)) & i_id_vld.
- Bubble: vld=0, inst=32'h00000013, ctrl=CTRL_NOP (all zero), pc/imm/data/is_load=0.
- Per-edge priority: flush > backend stall > load-use > advance.
  - flush: register bubble, FSM→IDLE, rem=0, o_id_stall=0.
  - i_ex_stall: all registers and FSM hold, o_id_stall=1.
  - load-use (hazard in IDLE, or STALL state): register bubble, o_id_stall=1, o_bubble_cnt+1 (saturates at all-ones).
  - advance: register Decode bundle with bypassed data.
- FSM: IDLE, STALL; rem counter width clog2(LOAD_LAT+1).
  - IDLE & hazard & no flush/stall: if LOAD_LAT>1 → STALL, rem=LOAD_LAT-1; else stay IDLE.
  - STALL: each non-held edge rem−1; when rem==1 → IDLE. Hazard re-check suppressed in STALL.
- Total bubbles per hazard = LOAD_LAT; flush bubbles never counted.
- Reset: all outputs as bubble, o_bubble_cnt=0, FSM IDLE, o_id_stall=0.

## Timing
- Latency ID→EX: 1 cycle.
- o_id_stall combinational from current EX register, FSM state and i_ex_flush/i_ex_stall; no register on this path.
- Bypass is same-cycle: WB write at edge t visible in EX data registered at edge t.
- Reset asserted mid-stall: immediate return to reset values, FSM IDLE.
- Flush in the hazard cycle wins: no bubble counted, no stall.
- i_ex_stall during STALL freezes rem; bubble count resumes after release.

## Structure
- Package decode_pkg: NOP_INST 32'h00000013, CTRL_NOP, state enum {IDLE, STALL}.
- One sub-module: load_use_detector (hazard compare, FSM, rem counter, o_id_stall); bypass muxes and ID/EX registers stay in top.

## Test plan
- lw x5 then add x6,x5,x1, LOAD_LAT=1 -> one cycle o_id_stall=1, one bubble (inst 0x13, vld 0), add reaches EX next cycle, o_bubble_cnt=1.
- Same sequence, LOAD_LAT=3 -> three consecutive bubbles, o_id_stall high 3 cycles, o_bubble_cnt=3.
- lw x0 then add x6,x0,x1; and lw x5 then lui x5 (no rs use) -> no stall, no bubble.
- WB writes x7=0xDEADBEEF while Decode reads x7 -> o_ex_rs1_data=0xDEADBEEF next cycle.
- i_ex_flush asserted in 2nd STALL cycle (LOAD_LAT=3) -> bubble, FSM IDLE, o_id_stall=0, count stops at 1; i_ex_stall for 2 cycles in STALL -> outputs hold, rem frozen.
- i_rst_n low mid-STALL, asynchronous -> outputs reset without clock edge, o_bubble_cnt=0; CNT_W=2 saturates at 3.
